// File: rtl/serial_subtractor_ctrl_if.sv
// Handshake/operand bundle for serial_subtractor_ctrl.
// Optional ovf signal present only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  // Requester side: issues operands and start, observes status/result.
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
    , input ovf
`endif
  );

  // Subtractor side.
  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell run once per clock,
// LSB first, borrow carried in a register. start/busy/done handshake.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  serial_subtractor_ctrl_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_ovf;
`endif

  logic w_ai;
  logic w_bi;
  logic w_d;
  logic w_br_next;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  always_comb begin
    w_ai      = r_a[0];
    w_bi      = r_b[0];
    w_d       = w_ai ^ w_bi ^ r_br;
    w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  end

  // Sequencer: latch on start, shift one bit per clock, pulse done, return to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_state <= StRun;
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_br    <= bus.bin;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_busy  <= 1'b1;
          end
        end
        StRun: begin
          // Result bits enter at the MSB so bit 0 ends up at diff[0].
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_a    <= {1'b0, r_a[WIDTH-1:1]};
          r_b    <= {1'b0, r_b[WIDTH-1:1]};
          r_br   <= w_br_next;
          r_cnt  <= r_cnt + CntW'(1);
          if (r_cnt == LastCnt) begin
            r_state <= StDone;
            r_bout  <= w_br_next;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            // r_br here is the borrow into the MSB.
            r_ovf   <= r_br ^ w_br_next;
`endif
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl: directed and random operands
// against an arithmetic reference model, plus hold-start and mid-run reset cases.
module tb_serial_subtractor_ctrl;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [W-1:0] s_a;
  logic [W-1:0] s_b;
  logic         s_bin;

  serial_subtractor_ctrl_if #(.WIDTH(W)) bus ();

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the latched operands.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                         input logic ibin);
    logic [W:0] full;
    full = {1'b0, ia} - {1'b0, ib} - {{W{1'b0}}, ibin};
    return full;  // [W] is the final borrow, [W-1:0] the difference
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic ibin);
    int s;
    s = int'($signed(ia)) - int'($signed(ib)) - int'(ibin);
    return (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
  endfunction

  // Present a request at the next falling edge; accepted at the following rising edge.
  task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ia;
    bus.b     = ib;
    bus.bin   = ibin;
  endtask

  // Wait for the acceptance edge, scramble inputs, then time and check the result.
  task automatic wait_and_check(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                input logic ibin, input bit hold_start);
    logic [W:0] exp;
    int n;
    int busy_cnt;
    exp = ref_sub(ia, ib, ibin);
    @(posedge clk);
    @(negedge clk);
    if (!hold_start) bus.start = 1'b0;
    s_a   = W'($urandom);
    s_b   = W'($urandom);
    s_bin = 1'($urandom);
    bus.a   = s_a;
    bus.b   = s_b;
    bus.bin = s_bin;
    n = 0;
    busy_cnt = 0;
    while (!bus.done && n < int'(W) + 4) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    check("done_latency", n, W);
    check("busy_cycles", busy_cnt, W);
    check("busy_at_done", {31'b0, bus.busy}, 0);
    check("diff", {24'b0, bus.diff}, {24'b0, exp[W-1:0]});
    check("bout", {31'b0, bus.bout}, {31'b0, exp[W]});
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", {31'b0, bus.ovf}, {31'b0, ref_ovf(ia, ib, ibin)});
`endif
    @(negedge clk);
    check("done_pulse_end", {31'b0, bus.done}, 0);
    check("busy_idle", {31'b0, bus.busy}, 0);
    check("diff_held", {24'b0, bus.diff}, {24'b0, exp[W-1:0]});
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
    launch(ia, ib, ibin);
    wait_and_check(ia, ib, ibin, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    #12;
    check("rst_busy", {31'b0, bus.busy}, 0);
    check("rst_done", {31'b0, bus.done}, 0);
    check("rst_diff", {24'b0, bus.diff}, 0);
    check("rst_bout", {31'b0, bus.bout}, 0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", {31'b0, bus.ovf}, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run_op(8'h05, 8'h03, 1'b0);
    run_op(8'h03, 8'h05, 1'b0);
    run_op(8'h00, 8'h00, 1'b1);
    run_op(8'h80, 8'h01, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0);

    // Single-bit truth table, upper bits zero.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run_op({7'b0, v[2]}, {7'b0, v[1]}, v[0]);
    end

    // Random operands.
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rbin;
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      run_op(ra, rb, rbin);
    end

    // start held high: first latched operands used, re-accept after WIDTH+2 edges.
    launch(8'h9C, 8'h27, 1'b1);
    wait_and_check(8'h9C, 8'h27, 1'b1, 1'b1);
    wait_and_check(s_a, s_b, s_bin, 1'b0);

    // Reset mid-run at cnt=4.
    launch(8'hA5, 8'h3C, 1'b0);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("busy_before_rst", {31'b0, bus.busy}, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, bus.busy}, 0);
    check("midrst_done", {31'b0, bus.done}, 0);
    check("midrst_diff", {24'b0, bus.diff}, 0);
    check("midrst_bout", {31'b0, bus.bout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h10, 8'h01, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
